// File: rtl/ft_pkg.sv
// Shared types and default widths for the fault-tolerant lockstep recovery path.
// Defaults match the write comparator feeding this block.
package ft_pkg;
   localparam int unsigned FT_ADDR_WIDTH   = 5;
   localparam int unsigned FT_DATA_WIDTH   = 32;
   localparam int unsigned FT_MAX_RETRIES  = 3;
   localparam int unsigned FT_CLEAN_WINDOW = 1024;

   typedef enum logic [2:0] {
      REC_RUN,
      REC_HALT,
      REC_RESTORE,
      REC_RESUME,
      REC_FATAL
   } rec_state_e;
endpackage

// File: rtl/ft_ckpt_rf.sv
// Protected checkpoint register file: one write port, one async read port.
// Entry 0 is never stored and always reads as zero.
module ft_ckpt_rf
   import ft_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = FT_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = FT_DATA_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   localparam int unsigned NREGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [NREGS];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      end else if (we_i && (waddr_i != '0)) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = (raddr_i == '0) ? '0 : mem_q[raddr_i];
endmodule

// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery controller: checkpoints agreed writes, replays them into both cores
// on a mismatch, and escalates to a sticky fatal after repeated mismatches.
//
// state       | meaning
// REC_RUN     | normal operation, committing agreed writes to the checkpoint
// REC_HALT    | one-cycle drain of in-flight writes, cores stalled
// REC_RESTORE | replaying checkpoint entries 1..NREGS-1, one per cycle
// REC_RESUME  | one-cycle settle before releasing the cores
// REC_FATAL   | unrecoverable, cores held until reset
module ft_recovery_ctrl
   import ft_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = FT_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH   = FT_DATA_WIDTH,
   parameter int unsigned MAX_RETRIES  = FT_MAX_RETRIES,
   parameter int unsigned CLEAN_WINDOW = FT_CLEAN_WINDOW
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 we_i,
   input  logic [ADDR_WIDTH-1:0]                addr_i,
   input  logic [DATA_WIDTH-1:0]                data_i,
   input  logic                                 mismatch_i,
   output logic                                 halt_o,
   output logic                                 restore_we_o,
   output logic [ADDR_WIDTH-1:0]                restore_addr_o,
   output logic [DATA_WIDTH-1:0]                restore_data_o,
   output logic                                 recovering_o,
   output logic                                 fatal_o,
   output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_cnt_o
);
   localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
   localparam int unsigned CLEAN_W = $clog2(CLEAN_WINDOW + 1);
   localparam logic [RETRY_W-1:0]    RETRY_MAX  = RETRY_W'(MAX_RETRIES);
   localparam logic [CLEAN_W-1:0]    CLEAN_LAST = CLEAN_W'(CLEAN_WINDOW - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = {ADDR_WIDTH{1'b1}};

   rec_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [RETRY_W-1:0]    retry_q, retry_d;
   logic [CLEAN_W-1:0]    clean_q, clean_d;
   logic                  ckpt_we;
   logic [DATA_WIDTH-1:0] ckpt_rdata;

   ft_ckpt_rf #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ckpt_rf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (ckpt_we),
      .waddr_i (addr_i),
      .wdata_i (data_i),
      .raddr_i (addr_d),
      .rdata_o (ckpt_rdata)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      retry_d = retry_q;
      clean_d = clean_q;
      ckpt_we = 1'b0;
      case (state_q)
         REC_RUN: begin
            // a mismatch beats both the write and a coincident clean-window expiry
            if (mismatch_i) begin
               clean_d = '0;
               if (retry_q != RETRY_MAX) retry_d = retry_q + RETRY_W'(1);
               state_d = (retry_d == RETRY_MAX) ? REC_FATAL : REC_HALT;
            end else begin
               ckpt_we = we_i && (addr_i != '0);
               if (clean_q == CLEAN_LAST) begin
                  clean_d = '0;
                  retry_d = '0;
               end else begin
                  clean_d = clean_q + CLEAN_W'(1);
               end
            end
         end
         REC_HALT: begin
            state_d = REC_RESTORE;
            addr_d  = ADDR_WIDTH'(1);
         end
         REC_RESTORE: begin
            if (addr_q == ADDR_LAST) state_d = REC_RESUME;
            else                     addr_d  = addr_q + ADDR_WIDTH'(1);
         end
         REC_RESUME: begin
            state_d = REC_RUN;
            addr_d  = '0;
         end
         REC_FATAL: state_d = REC_FATAL;
         default:   state_d = REC_RUN;
      endcase
   end

   // outputs are decoded from the next state so every port comes straight off a flop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= REC_RUN;
         addr_q         <= '0;
         retry_q        <= '0;
         clean_q        <= '0;
         halt_o         <= 1'b0;
         restore_we_o   <= 1'b0;
         restore_addr_o <= '0;
         restore_data_o <= '0;
         recovering_o   <= 1'b0;
         fatal_o        <= 1'b0;
         retry_cnt_o    <= '0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         retry_q        <= retry_d;
         clean_q        <= clean_d;
         halt_o         <= (state_d != REC_RUN);
         restore_we_o   <= (state_d == REC_RESTORE);
         restore_addr_o <= (state_d == REC_RESTORE) ? addr_d : '0;
         restore_data_o <= (state_d == REC_RESTORE) ? ckpt_rdata : '0;
         recovering_o   <= (state_d == REC_HALT) || (state_d == REC_RESTORE) ||
                           (state_d == REC_RESUME);
         fatal_o        <= (state_d == REC_FATAL);
         retry_cnt_o    <= retry_d;
      end
   end
endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Self-checking bench for ft_recovery_ctrl: directed scenarios plus random traffic
// compared every cycle against a cycle-count model of the recovery protocol.
module tb_ft_recovery_ctrl;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int MAXR  = 3;
   localparam int CW    = 1024;
   localparam int NREGS = 2 ** AW;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          we_i = 1'b0;
   logic [AW-1:0] addr_i = '0;
   logic [DW-1:0] data_i = '0;
   logic          mismatch_i = 1'b0;
   logic          halt_o, restore_we_o, recovering_o, fatal_o;
   logic [AW-1:0] restore_addr_o;
   logic [DW-1:0] restore_data_o;
   logic [1:0]    retry_cnt_o;

   ft_recovery_ctrl #(
      .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MAX_RETRIES (MAXR), .CLEAN_WINDOW (CW)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .we_i           (we_i),
      .addr_i         (addr_i),
      .data_i         (data_i),
      .mismatch_i     (mismatch_i),
      .halt_o         (halt_o),
      .restore_we_o   (restore_we_o),
      .restore_addr_o (restore_addr_o),
      .restore_data_o (restore_data_o),
      .recovering_o   (recovering_o),
      .fatal_o        (fatal_o),
      .retry_cnt_o    (retry_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // model: m_pos counts cycles into a recovery (0 = running, 1 = halt,
   // 2..NREGS = replay of entry m_pos-1, NREGS+1 = resume)
   logic [DW-1:0] m_ckpt [NREGS];
   int            m_retry, m_clean, m_pos;
   bit            m_fatal;

   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) m_ckpt[i] = '0;
      m_retry = 0; m_clean = 0; m_pos = 0; m_fatal = 0;
   endtask

   task automatic model_step(input bit we, input int a, input logic [DW-1:0] d, input bit mm);
      if (m_fatal) return;
      if (m_pos != 0) begin
         m_pos++;
         if (m_pos == NREGS + 2) m_pos = 0;
      end else if (mm) begin
         m_clean = 0;
         m_retry = (m_retry < MAXR) ? m_retry + 1 : MAXR;
         if (m_retry == MAXR) m_fatal = 1;
         else                 m_pos = 1;
      end else begin
         if (we && a != 0) m_ckpt[a] = d;
         m_clean++;
         if (m_clean == CW) begin
            m_clean = 0;
            m_retry = 0;
         end
      end
   endtask

   task automatic check_outputs();
      bit exp_we;
      exp_we = !m_fatal && m_pos >= 2 && m_pos <= NREGS;
      check_val("halt",         halt_o,         m_fatal || m_pos != 0);
      check_val("recovering",   recovering_o,   !m_fatal && m_pos != 0);
      check_val("fatal",        fatal_o,        m_fatal);
      check_val("restore_we",   restore_we_o,   exp_we);
      check_val("restore_addr", restore_addr_o, exp_we ? m_pos - 1 : 0);
      check_val("restore_data", restore_data_o, exp_we ? m_ckpt[m_pos-1] : 0);
      check_val("retry_cnt",    retry_cnt_o,    m_retry);
   endtask

   task automatic cycle(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit mm);
      we_i = we; addr_i = a; data_i = d; mismatch_i = mm;
      @(posedge clk_i);
      model_step(we, int'(a), d, mm);
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 1'b0);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      check_outputs();
   endtask

   logic [DW-1:0] cap [NREGS];
   bit            saw_addr0;

   // issue a mismatch and follow the recovery until halt falls (bounded)
   task automatic recover(input bit toggle, output int lat, output int we_cnt);
      for (int i = 0; i < NREGS; i++) cap[i] = 'x;
      saw_addr0 = 0;
      cycle(1'b0, '0, '0, 1'b1);
      lat = 1; we_cnt = 0;
      for (int k = 0; k < 60 && halt_o; k++) begin
         cycle(1'($urandom_range(0, 1)), AW'($urandom), $urandom,
               toggle ? 1'($urandom_range(0, 1)) : 1'b0);
         lat++;
         if (restore_we_o) begin
            we_cnt++;
            cap[restore_addr_o] = restore_data_o;
            if (restore_addr_o == '0) saw_addr0 = 1;
         end
      end
   endtask

   int lat, we_cnt;

   initial begin
      model_reset();
      do_reset();

      // checkpoint commit and full replay; x0 write must be dropped
      cycle(1'b1, AW'(5), 32'hDEADBEEF, 1'b0);
      cycle(1'b1, AW'(0), 32'h1, 1'b0);
      recover(1'b0, lat, we_cnt);
      check_val("t1_latency", lat, NREGS + 2);
      check_val("t1_we_cycles", we_cnt, NREGS - 1);
      check_val("t1_addr5_data", cap[5], 32'hDEADBEEF);
      check_val("t1_addr0_driven", saw_addr0, 0);
      check_val("t1_retry", retry_cnt_o, 1);

      // a write that arrives with a mismatch is never committed
      we_i = 1'b1; addr_i = AW'(7); data_i = 32'h55; mismatch_i = 1'b1;
      @(posedge clk_i); model_step(1'b1, 7, 32'h55, 1'b1); #1; check_outputs();
      for (int i = 0; i < NREGS; i++) cap[i] = 'x;
      for (int k = 0; k < 60 && halt_o; k++) begin
         cycle(1'b0, '0, '0, 1'b0);
         if (restore_we_o) cap[restore_addr_o] = restore_data_o;
      end
      check_val("t2_addr7_data", cap[7], 0);
      check_val("t2_retry", retry_cnt_o, 2);

      // clean window clears retries, boundary at CW-1 / CW cycles
      do_reset();
      recover(1'b0, lat, we_cnt);
      recover(1'b0, lat, we_cnt);
      idle(CW - 1);
      check_val("t4_retry_before_window", retry_cnt_o, 2);
      idle(1);
      check_val("t4_retry_after_window", retry_cnt_o, 0);

      // inputs toggling during recovery are ignored
      recover(1'b1, lat, we_cnt);
      check_val("t6_latency", lat, NREGS + 2);
      check_val("t6_retry", retry_cnt_o, 1);
      recover(1'b1, lat, we_cnt);
      check_val("t6_latency2", lat, NREGS + 2);
      check_val("t4_no_fatal", fatal_o, 0);

      // third mismatch without a clean window is fatal and sticky
      cycle(1'b0, '0, '0, 1'b1);
      for (int i = 0; i < 100; i++)
         cycle(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 1'($urandom_range(0, 1)));
      check_val("t3_fatal", fatal_o, 1);
      check_val("t3_halt", halt_o, 1);
      check_val("t3_retry", retry_cnt_o, MAXR);

      // async reset in the middle of a replay
      do_reset();
      for (int i = 1; i < NREGS; i++) cycle(1'b1, AW'(i), $urandom | 32'h1, 1'b0);
      cycle(1'b0, '0, '0, 1'b1);
      for (int k = 0; k < 60 && !(restore_we_o && restore_addr_o == AW'(12)); k++)
         cycle(1'b0, '0, '0, 1'b0);
      check_val("t5_reached_addr12", restore_addr_o, 12);
      #2 rst_ni = 1'b0;
      #1;
      check_val("t5_halt", halt_o, 0);
      check_val("t5_restore_we", restore_we_o, 0);
      check_val("t5_restore_addr", restore_addr_o, 0);
      check_val("t5_restore_data", restore_data_o, 0);
      check_val("t5_recovering", recovering_o, 0);
      check_val("t5_fatal", fatal_o, 0);
      check_val("t5_retry", retry_cnt_o, 0);
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      recover(1'b0, lat, we_cnt);
      check_val("t5_ckpt12_zero", cap[12], 0);
      check_val("t5_ckpt31_zero", cap[NREGS-1], 0);

      // random traffic against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cycle(1'($urandom_range(0, 1)), AW'($urandom), $urandom, ($urandom_range(0, 39) == 0));
         if (m_fatal && $urandom_range(0, 9) == 0) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
